// File: rtl/mmio_write_queue_if.sv
// mmio_write_queue_if: core store requests in, one-cycle MMIO write strobes out.
interface mmio_write_queue_if #(parameter int DEPTH = 4);
  logic                   in_valid;
  logic                   in_ready;
  logic [15:0]            in_addr;
  logic [7:0]             in_data;
  logic                   flush;
  logic [15:0]            mmio_out_addr;
  logic [7:0]             mmio_out;
  logic                   mmio_out_valid;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output in_valid, in_addr, in_data, flush,
    input  in_ready, mmio_out_addr, mmio_out, mmio_out_valid, count
  );
  modport slave (
    input  in_valid, in_addr, in_data, flush,
    output in_ready, mmio_out_addr, mmio_out, mmio_out_valid, count
  );
endinterface

// File: rtl/mmio_write_queue.sv
// mmio_write_queue: circular FIFO of MMIO stores, issuing one write per cycle on a registered bus.
module mmio_write_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] IDLE_ADDR = 16'h0000
) (
  input logic               clock,
  input logic               reset_n,
  mmio_write_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic          push, pop;
  assign q.in_ready = (cnt != CW'(DEPTH)) && !q.flush;
  assign push       = q.in_valid && q.in_ready;
  assign pop        = (cnt != '0) && !q.flush;
  assign q.count    = cnt;
  always_ff @(posedge clock)
    if (push) mem[wp] <= {q.in_addr, q.in_data};
  // Bus returns to idle on any edge without a pop so each write is strobed exactly once.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wp               <= '0;
      rp               <= '0;
      cnt              <= '0;
      q.mmio_out_addr  <= IDLE_ADDR;
      q.mmio_out       <= 8'h00;
      q.mmio_out_valid <= 1'b0;
    end else if (q.flush) begin
      wp               <= '0;
      rp               <= '0;
      cnt              <= '0;
      q.mmio_out_addr  <= IDLE_ADDR;
      q.mmio_out       <= 8'h00;
      q.mmio_out_valid <= 1'b0;
    end else begin
      wp               <= push ? wp + 1'b1 : wp;
      rp               <= pop ? rp + 1'b1 : rp;
      cnt              <= cnt + CW'(push) - CW'(pop);
      q.mmio_out_addr  <= pop ? mem[rp][23:8] : IDLE_ADDR;
      q.mmio_out       <= pop ? mem[rp][7:0] : 8'h00;
      q.mmio_out_valid <= pop;
    end
endmodule

// File: tb/tb_mmio_write_queue.sv
// tb_mmio_write_queue: randomized and directed scenarios checked against a queue-based reference model.
module tb_mmio_write_queue;
  localparam int          DEPTH = 4;
  localparam logic [15:0] IDLE  = 16'h0000;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  mmio_write_queue_if #(.DEPTH(DEPTH)) bus ();
  mmio_write_queue #(.DEPTH(DEPTH), .IDLE_ADDR(IDLE)) dut (.clock(clock), .reset_n(reset_n), .q(bus));
  int passed = 0;
  int total = 0;
  logic [23:0] mq [$];
  logic [27:0] e_out;
  logic        e_ready, r_ready;
  logic [27:0] obs;
  logic [7:0]  led_log [$];
  assign obs = {bus.mmio_out_addr, bus.mmio_out, bus.mmio_out_valid, bus.count};
  // LED peripheral at f000 latches on every cycle its address is driven with a valid strobe.
  always @(negedge clock)
    if (reset_n && bus.mmio_out_valid && bus.mmio_out_addr == 16'hf000) led_log.push_back(bus.mmio_out);

  task automatic step(input logic v, input logic [15:0] a, input logic [7:0] d, input logic f);
    logic [24:0] head;
    logic        full;
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.flush    = f;
    #1;
    e_ready = (mq.size() != DEPTH) && !f;
    r_ready = bus.in_ready;
    @(posedge clock);
    head = {IDLE, 8'h00, 1'b0};
    if (f) mq.delete();
    else begin
      full = (mq.size() == DEPTH);
      if (mq.size() != 0) head = {mq.pop_front(), 1'b1};
      if (v && !full) mq.push_back({a, d});
    end
    e_out = {head, 3'(mq.size())};
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_addr  = 16'h0;
    bus.in_data  = 8'h0;
    bus.flush    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (obs !== {IDLE, 8'h00, 1'b0, 3'd0}) $display("FAIL reset_outputs got %h exp %h", obs, {IDLE, 8'h00, 1'b0, 3'd0});
    else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", bus.in_ready);
    else passed++;
    mq.delete();
  endtask

  task automatic test_single();
    step(1'b1, 16'hf000, 8'h15, 1'b0);
    total++;
    if (obs !== {IDLE, 8'h00, 1'b0, 3'd1}) $display("FAIL single_accept got %h exp %h", obs, {IDLE, 8'h00, 1'b0, 3'd1});
    else passed++;
    step(1'b0, 16'h0, 8'h0, 1'b0);
    total++;
    if (obs !== {16'hf000, 8'h15, 1'b1, 3'd0}) $display("FAIL single_issue got %h exp %h", obs, {16'hf000, 8'h15, 1'b1, 3'd0});
    else passed++;
    step(1'b0, 16'h0, 8'h0, 1'b0);
    total++;
    if (obs !== {IDLE, 8'h00, 1'b0, 3'd0}) $display("FAIL single_idle got %h exp %h", obs, {IDLE, 8'h00, 1'b0, 3'd0});
    else passed++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 9; i++) begin
      step(i < 6, 16'h0100 + 16'(i), 8'(8'ha0 + i), 1'b0);
      total++;
      if (r_ready !== e_ready) $display("FAIL fill_ready cyc%0d got %b exp %b", i, r_ready, e_ready);
      else passed++;
      total++;
      if (obs !== e_out) $display("FAIL fill_bus cyc%0d got %h exp %h", i, obs, e_out);
      else passed++;
    end
  endtask

  task automatic test_idle_addr_write();
    step(1'b1, IDLE, 8'h5a, 1'b0);
    step(1'b0, 16'h0, 8'h0, 1'b0);
    total++;
    if (obs !== {IDLE, 8'h5a, 1'b1, 3'd0}) $display("FAIL idle_addr_write got %h exp %h", obs, {IDLE, 8'h5a, 1'b1, 3'd0});
    else passed++;
    step(1'b0, 16'h0, 8'h0, 1'b0);
  endtask

  task automatic test_flush();
    step(1'b1, 16'h0200, 8'h01, 1'b0);
    step(1'b1, 16'h0201, 8'h02, 1'b0);
    step(1'b1, 16'h0202, 8'h03, 1'b1);
    total++;
    if (r_ready !== 1'b0) $display("FAIL flush_ready got %b exp 0", r_ready);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs !== {IDLE, 8'h00, 1'b0, 3'd0}) $display("FAIL flush_idle cyc%0d got %h exp %h", i, obs, {IDLE, 8'h00, 1'b0, 3'd0});
      else passed++;
      step(1'b0, 16'h0, 8'h0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 16'h0300, 8'h11, 1'b0);
    step(1'b1, 16'h0301, 8'h22, 1'b0);
    reset_n = 1'b0;
    #1;
    total++;
    if (obs !== {IDLE, 8'h00, 1'b0, 3'd0}) $display("FAIL reset_mid got %h exp %h", obs, {IDLE, 8'h00, 1'b0, 3'd0});
    else passed++;
    mq.delete();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(i == 0, 16'h0302, 8'h33, 1'b0);
      total++;
      if (obs !== e_out) $display("FAIL reset_release cyc%0d got %h exp %h", i, obs, e_out);
      else passed++;
    end
  endtask

  task automatic test_led();
    led_log.delete();
    step(1'b1, 16'hf000, 8'h3f, 1'b0);
    step(1'b1, 16'hf000, 8'h00, 1'b0);
    repeat (4) step(1'b0, 16'h0, 8'h0, 1'b0);
    total++;
    if (led_log.size() != 2) $display("FAIL led_count got %0d exp 2", led_log.size());
    else passed++;
    total++;
    if (led_log.size() < 2 || led_log[0] !== 8'h3f || led_log[1] !== 8'h00)
      $display("FAIL led_values got %p exp 3f,00", led_log);
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] addrs [4];
    addrs[0] = 16'hf000;
    addrs[1] = IDLE;
    addrs[2] = 16'h1234;
    addrs[3] = 16'h00ff;
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, addrs[$urandom_range(0, 3)], 8'($urandom), $urandom_range(0, 15) == 0);
      total++;
      if (r_ready !== e_ready) $display("FAIL rand_ready cyc%0d got %b exp %b", i, r_ready, e_ready);
      else passed++;
      total++;
      if (obs !== e_out) $display("FAIL rand_bus cyc%0d got %h exp %h", i, obs, e_out);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_idle_addr_write();
    test_flush();
    test_reset_mid();
    test_led();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
